// File: rtl/wallace_mac_sequencer.sv
// Dot-product MAC sequencer feeding an external registered 8x8 multiplier.
// Build option SATURATE_EN: clamp acc_out to all ones once it overflows.
module wallace_mac_sequencer #(
   parameter int ACC_W    = 24,
   parameter int LEN_W    = 8,
   parameter int MULT_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a_in,
   input  logic [7:0]       b_in,
   output logic [7:0]       mult_a,
   output logic [7:0]       mult_b,
   input  logic [15:0]      mult_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             overflow
);
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic [LEN_W-1:0]    len_q, issued, returned;
   logic [LEN_W-1:0]    issued_inc, returned_inc;
   logic [MULT_LAT-1:0] tag;
   logic [ACC_W:0]      sum;
   logic                xfer, accum, last_issue, last_ret;

   assign busy      = (state != IDLE);
   assign in_ready  = (state == FEED) && (issued != len_q);
   assign out_valid = (state == DONE);
   assign xfer      = in_valid && in_ready;
   assign mult_a    = xfer ? a_in : 8'h00;
   assign mult_b    = xfer ? b_in : 8'h00;

   assign issued_inc   = issued + LEN_W'(1);
   assign returned_inc = returned + LEN_W'(1);
   assign sum = {1'b0, acc_out} + {{(ACC_W-15){1'b0}}, mult_p};

   // tag[MULT_LAT-1] marks the cycle a product is stable on mult_p
   assign accum = tag[MULT_LAT-1] &&
                  ((state == FEED) || (state == DRAIN));
   assign last_issue = xfer && (issued_inc == len_q);
   assign last_ret   = accum && (returned_inc == len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = (len == '0) ? DONE : FEED;
         FEED:    if (last_issue) state_nxt = DRAIN;
         DRAIN:   if (last_ret) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q    <= '0;
         issued   <= '0;
         returned <= '0;
         tag      <= '0;
         acc_out  <= '0;
         overflow <= 1'b0;
      end else begin
         tag <= MULT_LAT'({tag, xfer});
         if ((state == IDLE) && start) begin
            len_q    <= len;
            issued   <= '0;
            returned <= '0;
            acc_out  <= '0;
            overflow <= 1'b0;
         end else begin
            if (xfer) issued <= issued_inc;
            if (accum) begin
               returned <= returned_inc;
`ifdef SATURATE_EN
               // once clamped, later products are ignored
               if (sum[ACC_W] || overflow) begin
                  acc_out  <= '1;
                  overflow <= 1'b1;
               end else begin
                  acc_out <= sum[ACC_W-1:0];
               end
`else
               acc_out <= sum[ACC_W-1:0];
               if (sum[ACC_W]) overflow <= 1'b1;
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// Bench for wallace_mac_sequencer: 24-bit and 16-bit instances share stimulus
// and are compared every cycle against a job-level model of the MAC.
module tb_wallace_mac_sequencer;
   logic        clk = 0;
   logic        rst_n = 0;
   logic        start = 0, in_valid = 0, out_ready = 1;
   logic [7:0]  len = 0, a_in = 0, b_in = 0;
   logic        busy_w, busy_n, rdy_w, rdy_n;
   logic        ov_w, ov_n, of_w, of_n;
   logic [7:0]  ma_w, mb_w, ma_n, mb_n;
   logic [15:0] p1_w = 0, p2_w = 0, p1_n = 0, p2_n = 0;
   logic [23:0] acc_w;
   logic [15:0] acc_n;

   int     checks = 0, failures = 0, cyc = 0;
   bit     job = 0, feeding = 0;
   int     exp_len = 0, done_cyc = 0;
   longint prods[$];
   logic [7:0] va[$], vb[$];

   always #5 clk = ~clk;

   // exact multiplier, two register stages
   always @(posedge clk) begin
      p1_w <= 16'(ma_w) * 16'(mb_w);
      p2_w <= p1_w;
      p1_n <= 16'(ma_n) * 16'(mb_n);
      p2_n <= p1_n;
   end

   wallace_mac_sequencer #(.ACC_W(24), .LEN_W(8), .MULT_LAT(2)) u_w (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .busy(busy_w), .in_valid(in_valid), .in_ready(rdy_w),
      .a_in(a_in), .b_in(b_in), .mult_a(ma_w), .mult_b(mb_w),
      .mult_p(p2_w), .out_valid(ov_w), .out_ready(out_ready),
      .acc_out(acc_w), .overflow(of_w)
   );

   wallace_mac_sequencer #(.ACC_W(16), .LEN_W(8), .MULT_LAT(2)) u_n (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .busy(busy_n), .in_valid(in_valid), .in_ready(rdy_n),
      .a_in(a_in), .b_in(b_in), .mult_a(ma_n), .mult_b(mb_n),
      .mult_p(p2_n), .out_valid(ov_n), .out_ready(out_ready),
      .acc_out(acc_n), .overflow(of_n)
   );

   function automatic void chk(input string nm, input longint act,
                               input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t",
                  nm, act, exp, $time);
      end
   endfunction

   // job result from the list of accepted products
   function automatic void fold(input int w, output longint acc,
                                output bit ovf);
      longint m;
      m = (longint'(1) << w) - 1;
      acc = 0;
      ovf = 0;
      foreach (prods[i]) begin
         if (acc + prods[i] > m) begin
            ovf = 1;
`ifdef SATURATE_EN
            acc = m;
`else
            acc = (acc + prods[i]) & m;
`endif
         end else begin
            acc = acc + prods[i];
         end
      end
   endfunction

   always @(negedge clk) begin
      longint ew, en;
      bit     ow, on, xf, eov;
      cyc++;
      if (!rst_n) begin
         job = 0;
         feeding = 0;
         prods.delete();
         chk("rst_busy_w", busy_w, 0);
         chk("rst_busy_n", busy_n, 0);
         chk("rst_ready_w", rdy_w, 0);
         chk("rst_valid_w", ov_w, 0);
         chk("rst_acc_w", acc_w, 0);
         chk("rst_acc_n", acc_n, 0);
         chk("rst_ovf_w", of_w, 0);
         chk("rst_ovf_n", of_n, 0);
         chk("rst_mult_a", ma_w, 0);
         chk("rst_mult_b", mb_w, 0);
      end else begin
         eov = job && !feeding && (cyc >= done_cyc);
         chk("busy_w", busy_w, job);
         chk("busy_n", busy_n, job);
         chk("in_ready_w", rdy_w, feeding);
         chk("in_ready_n", rdy_n, feeding);
         chk("out_valid_w", ov_w, eov);
         chk("out_valid_n", ov_n, eov);
         if (eov) begin
            fold(24, ew, ow);
            fold(16, en, on);
            chk("acc_w", acc_w, ew);
            chk("ovf_w", of_w, ow);
            chk("acc_n", acc_n, en);
            chk("ovf_n", of_n, on);
         end
         xf = feeding && in_valid;
         chk("mult_a_w", ma_w, xf ? a_in : 8'h00);
         chk("mult_b_w", mb_w, xf ? b_in : 8'h00);
         chk("mult_a_n", ma_n, xf ? a_in : 8'h00);
         chk("mult_b_n", mb_n, xf ? b_in : 8'h00);
         if (!job && start) begin
            job = 1;
            exp_len = int'(len);
            prods.delete();
            feeding = (len != 0);
            done_cyc = (len == 0) ? cyc + 1 : 32'h7fffffff;
         end else if (xf) begin
            prods.push_back(longint'(a_in) * longint'(b_in));
            if (prods.size() == exp_len) begin
               feeding = 0;
               done_cyc = cyc + 3;
            end
         end
         if (eov && out_ready) job = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bub < 0 selects strictly alternating bubbles
   task automatic run_job(input int bub, input int stall, input bit poke,
                          output longint rw, output longint rn,
                          output bit fw, output bit fn);
      int idx, guard;
      idx = 0;
      guard = 0;
      out_ready = (stall == 0);
      start = 1;
      len = 8'(va.size());
      tick();
      start = 0;
      len = 0;
      while (idx < va.size() && guard < 1000) begin
         if (bub < 0) in_valid = guard[0];
         else in_valid = ($urandom_range(99) >= bub);
         a_in = in_valid ? va[idx] : 8'($urandom);
         b_in = in_valid ? vb[idx] : 8'($urandom);
         start = poke && (idx == 1);
         len = start ? 8'd3 : 8'd0;
         @(negedge clk);
         if (in_valid && rdy_w) idx++;
         tick();
         guard++;
      end
      in_valid = 0;
      start = 0;
      len = 0;
      chk("feed_timeout", guard >= 1000, 0);
      guard = 0;
      @(negedge clk);
      while (!ov_w && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("done_timeout", guard >= 50, 0);
      rw = acc_w;
      rn = acc_n;
      fw = of_w;
      fn = of_n;
      repeat (stall) tick();
      out_ready = 1;
      tick();
      chk("idle_after", busy_w, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      longint rw, rn;
      bit     fw, fn;
      int     idx, guard;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      tick();

      va = '{8'd3, 8'd10, 8'd255};
      vb = '{8'd5, 8'd10, 8'd255};
      run_job(0, 0, 0, rw, rn, fw, fn);
      chk("t1_acc_w", rw, 65140);
      chk("t1_ovf_w", fw, 0);
      chk("t1_acc_n", rn, 65140);

      run_job(-1, 0, 0, rw, rn, fw, fn);
      chk("t2_acc_w", rw, 65140);

      va = '{8'd255, 8'd255};
      vb = '{8'd255, 8'd255};
      run_job(0, 0, 0, rw, rn, fw, fn);
      chk("t3_acc_w", rw, 130050);
      chk("t3_ovf_w", fw, 0);
`ifdef SATURATE_EN
      chk("t3_acc_n", rn, 65535);
`else
      chk("t3_acc_n", rn, 64514);
`endif
      chk("t3_ovf_n", fn, 1);

      va.delete();
      vb.delete();
      run_job(0, 5, 0, rw, rn, fw, fn);
      chk("t4_acc_w", rw, 0);
      chk("t4_ovf_w", fw, 0);

      va = '{8'd1, 8'd2, 8'd3, 8'd4};
      vb = '{8'd5, 8'd6, 8'd7, 8'd8};
      run_job(0, 3, 1, rw, rn, fw, fn);
      chk("t5_acc_w", rw, 70);

      va = '{8'd200, 8'd201, 8'd202, 8'd203};
      vb = '{8'd250, 8'd251, 8'd252, 8'd253};
      start = 1;
      len = 8'd4;
      tick();
      start = 0;
      len = 0;
      idx = 0;
      guard = 0;
      while (idx < 2 && guard < 20) begin
         in_valid = 1;
         a_in = va[idx];
         b_in = vb[idx];
         @(negedge clk);
         if (rdy_w) idx++;
         tick();
         guard++;
      end
      in_valid = 0;
      rst_n = 0;
      @(negedge clk);
      chk("t6_busy", busy_w, 0);
      chk("t6_acc", acc_w, 0);
      tick();
      rst_n = 1;
      va = '{8'd7};
      vb = '{8'd9};
      run_job(0, 0, 0, rw, rn, fw, fn);
      chk("t6_acc_w", rw, 63);
      chk("t6_acc_n", rn, 63);

      for (int j = 0; j < 40; j++) begin
         int n;
         va.delete();
         vb.delete();
         n = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1));
         if (j == 20) n = 40;
         for (int i = 0; i < n; i++) begin
            va.push_back(($urandom_range(2) == 0) ? 8'hFF : 8'($urandom));
            vb.push_back(($urandom_range(2) == 0) ? 8'hFF : 8'($urandom));
         end
         run_job(int'($urandom_range(60)), int'($urandom_range(3)),
                 bit'($urandom_range(1)), rw, rn, fw, fn);
      end

      repeat (5) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
